fpga_bram_arbiter: RTL
======================

// Module: fpga_bram_arbiter
// PURPOSE
// - Shares one single-port FPGA BRAM (native ena/wea/addra/dina/douta port) between NUM_REQ requesters,
//   e.g. the instruction fetch port and the data port of the core.
// - One access in flight at a time, round-robin grant, request/response handshake towards requesters.
// - Sits between the requesters and the BRAM; requesters never drive the BRAM directly.
// PARAMETERS
// - NUM_REQ        2   number of requesters (>=2)
// - DATA_WIDTH     64  data word width, bits
// - ADDRESS_WIDTH  32  word address width, bits
// PORTS
// - clk          in   1                     single clock, all logic on posedge
// - rst          in   1                     asynchronous, active-low reset (asserted when 0)
// - req_read_i   in   NUM_REQ               per-requester read request, level, held until its resp_o
// - req_write_i  in   NUM_REQ               per-requester write request, level, held until its resp_o
// - req_addr_i   in   NUM_REQ*ADDRESS_WIDTH per-requester word address
// - req_wdata_i  in   NUM_REQ*DATA_WIDTH    per-requester write data
// - req_resp_o   out  NUM_REQ               one-cycle completion pulse to the granted requester
// - req_rdata_o  out  DATA_WIDTH            read data, valid only while req_resp_o bit of a read is 1
// - bram_ena_o   out  1                     BRAM enable
// - bram_wea_o   out  1                     BRAM write enable (meaningful only with ena)
// - bram_addra_o out  ADDRESS_WIDTH         BRAM address
// - bram_dina_o  out  DATA_WIDTH            BRAM write data
// - bram_douta_i in   DATA_WIDTH            BRAM read data, valid the cycle after ena&~wea
// - bram_error_i in   1                     BRAM error flag
// - error_o      out  1                     sticky error: BRAM error or protocol violation
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE, rr pointer=0, req_resp_o=0, bram_ena_o=0, bram_wea_o=0,
//   bram_addra_o=0, bram_dina_o=0, req_rdata_o=0, error_o=0. Reset mid-access aborts it: no resp_o issued;
//   a write in ISSUE may or may not have landed in BRAM.
// - FSM: IDLE -> ISSUE -> RESP -> IDLE.
//   IDLE: if any req_read_i|req_write_i, pick winner g by round robin starting at pointer; register g,
//     op (write if req_write_i[g]), addr, wdata. Pointer <= (g+1) mod NUM_REQ. Else stay.
//   ISSUE: bram_ena_o=1, bram_wea_o=op, bram_addra_o/bram_dina_o = registered values. Always -> RESP.
//   RESP: req_resp_o[g]=1 for exactly this cycle; reads: req_rdata_o = bram_douta_i. -> IDLE.
// - Outputs are registered (driven from state/capture regs); bram_ena_o=0 in IDLE and RESP.
// - Latency: request first seen in IDLE at edge E -> ISSUE cycle -> resp in cycle after ISSUE
//   (2 cycles after E). Max throughput one access per 3 cycles.
// - Requester deasserts request on the edge ending its resp cycle; a request still high in the following
//   IDLE cycle is treated as a new access.
// - Arbitration only in IDLE; requests arriving during ISSUE/RESP wait. With N requesters continuously
//   requesting, each is granted once every N accesses (no starvation).
// - Same requester with read and write both 1: write is served, error_o <= 1.
// - bram_error_i=1 on any cycle sets error_o; error_o clears only on reset.
// - Simulation only: $error on 'x in req_addr_i of the winner at grant, or in wdata of a granted write.
// STRUCTURE
// - fpga_bram_arb_pkg: state enum (IDLE, ISSUE, RESP), op enum (OP_READ, OP_WRITE).
// - Sub-module rr_arbiter #(NUM_REQ): req vector + pointer in, one-hot grant + index out; pointer
//   register with update enable lives inside it.
// - Top: FSM, capture registers, output muxing, error flag.
// TESTING
// - Read: preload mem[0x10]=0xDEAD_BEEF_0000_0001; req0 read 0x10 -> ena=1,wea=0 one cycle, then
//   req_resp_o=01 with rdata 0xDEAD_BEEF_0000_0001 two cycles after request seen.
// - Write/readback: req1 write 0x20 data 0x1234 -> resp 10; then req1 read 0x20 -> rdata 0x1234.
// - Contention: req0 and req1 both read from reset -> grant 0 first, then 1; held continuously -> grants
//   alternate 0,1,0,1; no resp pulse wider than one cycle.
// - Reset mid-op: drop rst in ISSUE -> ena, resp, error immediately 0, state IDLE; no resp after release.
// - Protocol error: req0 read&write together at 0x30 data 0x5 -> write served, resp 01, error_o=1 sticky
//   until reset; mem[0x30]=0x5.
// - bram_error_i pulse for one cycle in IDLE -> error_o=1 next cycle and stays 1.

Source files
------------

// File: rtl/fpga_bram_arb_pkg.sv
// Shared types for the BRAM arbiter: FSM states and access kind.
package fpga_bram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/fpga_bram_arbiter_rr_arbiter.sv
// Round-robin pick among a request vector, searching upward from a stored pointer.
// Latency: combinational grant; the pointer moves on the clock edge where update is high.
// Backpressure: none; the caller decides when a grant is taken by asserting update.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               k;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req[IDX_W'(k)]) begin
        found     = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    grant = found ? (NUM_REQ'(1) << grant_idx) : '0;
  end

  // Winner goes to the back of the queue: next search starts just past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (update) begin
      ptr_q <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/fpga_bram_arbiter.sv
// Shares one single-port BRAM between NUM_REQ requesters, one access in flight, round-robin.
// Latency: grant edge -> one ISSUE cycle -> one-cycle resp pulse (2 cycles after the grant edge).
// Backpressure: requests are levels held until resp; losers simply wait in place.
module fpga_bram_arbiter
  import fpga_bram_arb_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_read_i,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]              req_resp_o,
  output logic [DATA_WIDTH-1:0]           req_rdata_o,
  output logic                            bram_ena_o,
  output logic                            bram_wea_o,
  output logic [ADDRESS_WIDTH-1:0]        bram_addra_o,
  output logic [DATA_WIDTH-1:0]           bram_dina_o,
  input  logic [DATA_WIDTH-1:0]           bram_douta_i,
  input  logic                            bram_error_i,
  output logic                            error_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                   state_q, state_d;
  op_e                      op_q;
  logic [IDX_W-1:0]         g_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     error_q;

  logic [NUM_REQ-1:0]       req_any;
  logic [NUM_REQ-1:0]       grant_oh;
  logic [IDX_W-1:0]         grant_idx;
  logic                     update;
  logic [ADDRESS_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]    wdata_arr [NUM_REQ];

  assign req_any = req_read_i | req_write_i;
  assign update  = (state_q == IDLE) && (|req_any);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr_i[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      wdata_arr[i] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (req_any),
    .update    (update),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_any) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write wins when a requester raises both; that case is also flagged as an error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q     <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (update) begin
      g_q     <= grant_idx;
      op_q    <= req_write_i[grant_idx] ? OP_WRITE : OP_READ;
      addr_q  <= addr_arr[grant_idx];
      wdata_q <= wdata_arr[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if (bram_error_i ||
                 (update && req_read_i[grant_idx] && req_write_i[grant_idx])) begin
      error_q <= 1'b1;
    end
  end

  assign bram_ena_o   = (state_q == ISSUE);
  assign bram_wea_o   = (state_q == ISSUE) && (op_q == OP_WRITE);
  assign bram_addra_o = addr_q;
  assign bram_dina_o  = wdata_q;
  assign req_resp_o   = (state_q == RESP) ? (NUM_REQ'(1) << g_q) : '0;
  assign req_rdata_o  = ((state_q == RESP) && (op_q == OP_READ)) ? bram_douta_i : '0;
  assign error_o      = error_q;

  a_addr_known: assert property (@(posedge clk) disable iff (!rst)
    update |-> !$isunknown(addr_arr[grant_idx]))
    else $error("unknown address from granted requester");

  a_wdata_known: assert property (@(posedge clk) disable iff (!rst)
    (update && req_write_i[grant_idx]) |-> !$isunknown(wdata_arr[grant_idx]))
    else $error("unknown write data from granted requester");

  logic unused_grant_oh;
  assign unused_grant_oh = |grant_oh;

endmodule
